// File: rtl/sfu_acc_relu.sv
// Saturating psum accumulation bank with a clear-on-read ready/valid drain and optional per-lane ReLU.
// Sits between the systolic array's column psum outputs and the output write-back path.
module sfu_acc_relu #(
    parameter int unsigned psum_bw = 16,
    parameter int unsigned col     = 8,
    parameter int unsigned depth   = 16,
    parameter int unsigned addr_bw = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [addr_bw-1:0]       in_addr,
    input  logic                     in_first,
    input  logic [psum_bw*col-1:0]   in_psum,
    input  logic                     relu_en,
    input  logic                     drain_start,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [addr_bw-1:0]       out_addr,
    output logic [psum_bw*col-1:0]   out_data,
    output logic                     drain_done,
    output logic                     sat_flag
);

    localparam int unsigned ROW_W = psum_bw * col;
    localparam int unsigned IDX_W = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [addr_bw-1:0] LAST_ADDR = addr_bw'(depth - 1);
    localparam logic [psum_bw-1:0] LANE_MAX  = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] LANE_MIN  = {1'b1, {(psum_bw-1){1'b0}}};

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [ROW_W-1:0]       r_bank [depth];
    logic [addr_bw-1:0]     r_rd_ptr;
    logic                   r_relu;
    logic                   r_sat;
    logic                   r_out_valid;
    logic                   r_in_ready;
    logic                   r_drain_done;
    logic [ROW_W-1:0]       r_out_data;

    logic                   w_acc;
    logic                   w_addr_ok;
    logic                   w_wr_en;
    logic [IDX_W-1:0]       w_wr_idx;
    logic [IDX_W-1:0]       w_rd_idx;
    logic [IDX_W-1:0]       w_nxt_idx;
    logic [ROW_W-1:0]       w_cur_row;
    logic [ROW_W-1:0]       w_wr_row;
    logic [ROW_W-1:0]       w_row0;
    logic [col-1:0]         w_lane_sat;
    logic                   w_sat_hit;
    logic                   w_start;
    logic                   w_beat;
    logic                   w_last;

    // Zero negative lanes when enabled.
    function automatic logic [ROW_W-1:0] relu_row(input logic [ROW_W-1:0] row, input logic en);
        relu_row = row;
        for (int l = 0; l < int'(col); l++) begin
            if (en && row[l*int'(psum_bw) + int'(psum_bw) - 1]) begin
                relu_row[l*int'(psum_bw) +: psum_bw] = '0;
            end
        end
    endfunction

    assign w_acc     = in_valid && (r_state == S_IDLE);
    assign w_addr_ok = 32'(in_addr) < 32'(depth);
    assign w_wr_en   = w_acc && w_addr_ok;
    assign w_wr_idx  = in_addr[IDX_W-1:0];
    assign w_rd_idx  = r_rd_ptr[IDX_W-1:0];
    assign w_nxt_idx = w_rd_idx + IDX_W'(1);
    assign w_cur_row = r_bank[w_wr_idx];
    assign w_sat_hit = w_wr_en && !in_first && (|w_lane_sat);

    // Entry 0 as it will be after this edge, so a write coinciding with drain_start is drained.
    assign w_row0 = (w_wr_en && (w_wr_idx == '0)) ? w_wr_row : r_bank[0];

    for (genvar l = 0; l < int'(col); l++) begin : g_lane
        logic [psum_bw-1:0] w_a;
        logic [psum_bw-1:0] w_b;
        logic [psum_bw:0]   w_sum;
        logic               w_ovf;

        assign w_a   = w_cur_row[l*psum_bw +: psum_bw];
        assign w_b   = in_psum[l*psum_bw +: psum_bw];
        assign w_sum = {w_a[psum_bw-1], w_a} + {w_b[psum_bw-1], w_b};
        // Sign bit and extension bit disagree only on overflow.
        assign w_ovf = w_sum[psum_bw] ^ w_sum[psum_bw-1];
        assign w_lane_sat[l] = w_ovf;
        assign w_wr_row[l*psum_bw +: psum_bw] =
            in_first ? w_b : (w_ovf ? (w_sum[psum_bw] ? LANE_MIN : LANE_MAX) : w_sum[psum_bw-1:0]);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_beat      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (drain_start) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    w_beat = 1'b1;
                    if (r_rd_ptr == LAST_ADDR) begin
                        w_last      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bank storage: accumulate in IDLE, clear-on-read in DRAIN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < int'(depth); e++) begin
                r_bank[e] <= '0;
            end
        end else if (w_wr_en) begin
            r_bank[w_wr_idx] <= w_wr_row;
        end else if (w_beat) begin
            r_bank[w_rd_idx] <= '0;
        end
    end

    // Registered drain outputs, relu latch and sticky saturation flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr     <= '0;
            r_relu       <= 1'b0;
            r_sat        <= 1'b0;
            r_out_valid  <= 1'b0;
            r_in_ready   <= 1'b1;
            r_drain_done <= 1'b0;
            r_out_data   <= '0;
        end else begin
            r_drain_done <= 1'b0;
            if (w_start) begin
                r_relu      <= relu_en;
                r_sat       <= w_sat_hit;
                r_rd_ptr    <= '0;
                r_out_valid <= 1'b1;
                r_in_ready  <= 1'b0;
                r_out_data  <= relu_row(w_row0, relu_en);
            end else begin
                r_sat <= r_sat | w_sat_hit;
                if (w_last) begin
                    r_rd_ptr     <= '0;
                    r_out_valid  <= 1'b0;
                    r_in_ready   <= 1'b1;
                    r_drain_done <= 1'b1;
                    r_out_data   <= '0;
                end else if (w_beat) begin
                    r_rd_ptr   <= r_rd_ptr + addr_bw'(1);
                    r_out_data <= relu_row(r_bank[w_nxt_idx], r_relu);
                end
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_addr   = r_rd_ptr;
    assign out_data   = r_out_data;
    assign drain_done = r_drain_done;
    assign sat_flag   = r_sat;

endmodule

// File: tb/tb_sfu_acc_relu.sv
// Directed bench for sfu_acc_relu with psum_bw=16, col=4, depth=4, addr_bw=2.
// Inputs change 1 ns after the rising edge; outputs are sampled at that point too.
module tb_sfu_acc_relu;

    localparam int unsigned PB = 16;
    localparam int unsigned NC = 4;
    localparam int unsigned ND = 4;
    localparam int unsigned AB = 2;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [AB-1:0]     in_addr;
    logic              in_first;
    logic [PB*NC-1:0]  in_psum;
    logic              relu_en;
    logic              drain_start;
    logic              out_valid;
    logic              out_ready;
    logic [AB-1:0]     out_addr;
    logic [PB*NC-1:0]  out_data;
    logic              drain_done;
    logic              sat_flag;

    int n_checks = 0;
    int n_errors = 0;

    sfu_acc_relu #(.psum_bw(PB), .col(NC), .depth(ND), .addr_bw(AB)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_first(in_first), .in_psum(in_psum),
        .relu_en(relu_en), .drain_start(drain_start),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .drain_done(drain_done), .sat_flag(sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        pk = {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AB-1:0] a, input logic first, input logic [63:0] d);
        in_valid = 1'b1; in_addr = a; in_first = first; in_psum = d;
        tick;
        in_valid = 1'b0; in_first = 1'b0; in_psum = '0;
    endtask

    // Full drain with out_ready held high; optional write to entry 0 in the start cycle.
    task automatic drain4(input string tag, input logic relu, input logic wr0, input logic [63:0] wdat,
                          input logic [63:0] e0, input logic [63:0] e1,
                          input logic [63:0] e2, input logic [63:0] e3);
        logic [63:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        drain_start = 1'b1; relu_en = relu; out_ready = 1'b1;
        if (wr0) begin
            in_valid = 1'b1; in_addr = '0; in_first = 1'b1; in_psum = wdat;
        end
        tick;
        drain_start = 1'b0; relu_en = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_psum = '0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_valid%0d", tag, i), 64'(out_valid), 64'd1);
            chk($sformatf("%s_inrdy%0d", tag, i), 64'(in_ready), 64'd0);
            chk($sformatf("%s_addr%0d", tag, i), 64'(out_addr), 64'(i));
            chk($sformatf("%s_data%0d", tag, i), out_data, e[i]);
            chk($sformatf("%s_ndone%0d", tag, i), 64'(drain_done), 64'd0);
            tick;
        end
        chk({tag, "_done"}, 64'(drain_done), 64'd1);
        chk({tag, "_vld_off"}, 64'(out_valid), 64'd0);
        chk({tag, "_inrdy_on"}, 64'(in_ready), 64'd1);
        tick;
        chk({tag, "_done_pulse"}, 64'(drain_done), 64'd0);
    endtask

    logic [63:0] exp_bp [4];
    logic        rdy_pat [4];
    int          beat;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_first = 1'b0; in_psum = '0;
        relu_en = 1'b0; drain_start = 1'b0; out_ready = 1'b0;
        #3;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_drain_done", 64'(drain_done), 64'd0);
        chk("rst_sat_flag", 64'(sat_flag), 64'd0);
        tick; tick;
        reset = 1'b0;
        tick;

        // Accumulate then plain drain.
        wr(2'd1, 1'b1, pk(1, 2, 3, 4));
        wr(2'd1, 1'b0, pk(10, -20, 30, -40));
        drain4("acc", 1'b0, 1'b0, '0, '0, pk(11, -18, 33, -36), '0, '0);
        chk("acc_sat", 64'(sat_flag), 64'd0);

        // ReLU drain, then an immediate second drain sees cleared entries.
        wr(2'd1, 1'b1, pk(1, 2, 3, 4));
        wr(2'd1, 1'b0, pk(10, -20, 30, -40));
        drain4("relu", 1'b1, 1'b0, '0, '0, pk(11, 0, 33, 0), '0, '0);
        drain4("clr", 1'b0, 1'b0, '0, '0, '0, '0, '0);

        // Positive saturation, sat_flag cleared by the next drain_start.
        wr(2'd2, 1'b1, pk(32760, 0, 0, 0));
        chk("psat_pre", 64'(sat_flag), 64'd0);
        wr(2'd2, 1'b0, pk(100, 0, 0, 0));
        chk("psat_flag", 64'(sat_flag), 64'd1);
        drain4("psat", 1'b0, 1'b0, '0, '0, '0, pk(32767, 0, 0, 0), '0);
        chk("psat_cleared", 64'(sat_flag), 64'd0);

        // Negative saturation.
        wr(2'd3, 1'b1, pk(-32760, 0, 0, 0));
        wr(2'd3, 1'b0, pk(-100, 0, 0, 0));
        chk("nsat_flag", 64'(sat_flag), 64'd1);
        drain4("nsat", 1'b0, 1'b0, '0, '0, '0, '0, pk(-32768, 0, 0, 0));

        // Backpressure with mid-drain writes that must be ignored.
        wr(2'd1, 1'b1, pk(7, 8, 9, 10));
        wr(2'd3, 1'b1, pk(-1, -2, -3, -4));
        exp_bp[0] = '0; exp_bp[1] = pk(7, 8, 9, 10); exp_bp[2] = '0; exp_bp[3] = pk(-1, -2, -3, -4);
        rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;
        drain_start = 1'b1; relu_en = 1'b0; out_ready = 1'b0;
        tick;
        drain_start = 1'b0;
        beat = 0;
        for (int cyc = 0; cyc < 40 && beat < 4; cyc++) begin
            chk($sformatf("bp_valid_c%0d", cyc), 64'(out_valid), 64'd1);
            chk($sformatf("bp_inrdy_c%0d", cyc), 64'(in_ready), 64'd0);
            chk($sformatf("bp_addr_c%0d", cyc), 64'(out_addr), 64'(beat));
            chk($sformatf("bp_data_c%0d", cyc), out_data, exp_bp[beat]);
            out_ready = rdy_pat[cyc % 4];
            if (cyc >= 2 && cyc <= 4) begin
                in_valid = 1'b1; in_addr = 2'd2; in_first = 1'b1; in_psum = pk(99, 99, 99, 99);
            end else begin
                in_valid = 1'b0; in_first = 1'b0; in_psum = '0;
            end
            tick;
            if (rdy_pat[cyc % 4]) beat++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("bp_beats", 64'(beat), 64'd4);
        chk("bp_done", 64'(drain_done), 64'd1);
        chk("bp_vld_off", 64'(out_valid), 64'd0);
        tick;
        drain4("bp_after", 1'b0, 1'b0, '0, '0, '0, '0, '0);

        // Write coinciding with drain_start is visible in the drain.
        drain4("simul", 1'b0, 1'b1, pk(5, 5, 5, 5), pk(5, 5, 5, 5), '0, '0, '0);

        // Reset after two accepted beats.
        wr(2'd2, 1'b1, pk(3, 3, 3, 3));
        wr(2'd3, 1'b1, pk(4, 4, 4, 4));
        drain_start = 1'b1; out_ready = 1'b1;
        tick;
        drain_start = 1'b0;
        tick; tick;
        chk("mid_addr", 64'(out_addr), 64'd2);
        chk("mid_data", out_data, pk(3, 3, 3, 3));
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_inrdy", 64'(in_ready), 64'd1);
        chk("mid_rst_done", 64'(drain_done), 64'd0);
        tick;
        reset = 1'b0;
        out_ready = 1'b0;
        tick;
        chk("mid_post_done", 64'(drain_done), 64'd0);
        chk("mid_post_valid", 64'(out_valid), 64'd0);
        drain4("mid_zero", 1'b0, 1'b0, '0, '0, '0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
